// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - shared widths, burst-length floor and FSM state type for the deserializer
package deserializer_pkg;

    localparam int DEFAULT_DATA_BUS_WIDTH = 16;
    localparam int DEFAULT_DATA_MOD_WIDTH = 4;

    // Shorter bursts are treated as line noise and dropped.
    localparam int MIN_BURST_LEN = 3;

    typedef enum logic {
        IDLE_S = 1'b0,
        RECV_S = 1'b1
    } state_t;

endpackage

// File: rtl/deser_shift_buf.sv
// rtl/deser_shift_buf.sv - indexed bit-insertion buffer that assembles the parallel word
module deser_shift_buf #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic             bit_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] word_o,
    output logic [WIDTH-1:0] word_ins_o
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            word_q <= '0;
        end else if (wr_en_i) begin
            word_q[idx_i] <= bit_i;
        end
    end

    // Word as it would look with the current bit inserted; lets the owner
    // emit a completed word on the same edge the buffer is cleared.
    always_comb begin
        word_ins_o = word_q;
        word_ins_o[idx_i] = bit_i;
    end

    assign word_o = word_q;

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel burst collector; DESERIALIZER_ERR_EN adds the err_o discard flag
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEFAULT_DATA_BUS_WIDTH,
    parameter int DATA_MOD_WIDTH = DEFAULT_DATA_MOD_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
`ifdef DESERIALIZER_ERR_EN
    output logic                      err_o,
`endif
    output logic                      busy_o
);

    localparam int CNT_W = DATA_MOD_WIDTH + 1;
    localparam int IDX_W = (DATA_BUS_WIDTH > 1) ? $clog2(DATA_BUS_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BUS_WIDTH - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_BURST_LEN);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  buf_we, buf_clr;
    logic [IDX_W-1:0]      buf_idx;
    logic [DATA_BUS_WIDTH-1:0] buf_word, buf_ins;
    logic                  emit, emit_full;
`ifdef DESERIALIZER_ERR_EN
    logic                  discard;
`endif

    // cnt_q is 0 in IDLE_S, so one expression covers both states.
    assign buf_idx = IDX_W'(LAST_CNT - cnt_q);

    deser_shift_buf #(
        .WIDTH (DATA_BUS_WIDTH),
        .IDX_W (IDX_W)
    ) u_shift_buf (
        .clk_i      (clk_i),
        .clear_i    (buf_clr | srst_i),
        .wr_en_i    (buf_we),
        .bit_i      (ser_data_i),
        .idx_i      (buf_idx),
        .word_o     (buf_word),
        .word_ins_o (buf_ins)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE_S;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_we    = 1'b0;
        buf_clr   = 1'b0;
        emit      = 1'b0;
        emit_full = 1'b0;
`ifdef DESERIALIZER_ERR_EN
        discard   = 1'b0;
`endif
        case (state_q)
            IDLE_S: begin
                if (ser_data_val_i) begin
                    buf_we  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = RECV_S;
                end
            end
            RECV_S: begin
                if (ser_data_val_i) begin
                    buf_we = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        emit      = 1'b1;
                        emit_full = 1'b1;
                        buf_clr   = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE_S;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    buf_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE_S;
                    if (cnt_q >= MIN_CNT) begin
                        emit = 1'b1;
                    end
`ifdef DESERIALIZER_ERR_EN
                    else begin
                        discard = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE_S;
                cnt_d   = '0;
                buf_clr = 1'b1;
            end
        endcase
    end

    // Output word and mod hold between strobes; a full word reports mod 0.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= emit;
            if (emit) begin
                deser_data_o     <= emit_full ? buf_ins : buf_word;
                deser_data_mod_o <= emit_full ? '0 : cnt_q[DATA_MOD_WIDTH-1:0];
            end
        end
    end

`ifdef DESERIALIZER_ERR_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= discard;
        end
    end
`endif

    assign busy_o = (state_q == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer
module tb_deserializer;

    logic        clk;
    logic        srst;
    logic        ser_data;
    logic        ser_data_val;
    logic [15:0] deser_data;
    logic [3:0]  deser_data_mod;
    logic        deser_data_val;
    logic        busy;
`ifdef DESERIALIZER_ERR_EN
    logic        err;
    int          err_pulses = 0;
`endif

    int compared   = 0;
    int mismatched = 0;
    int strobes    = 0;

    deserializer #(
        .DATA_BUS_WIDTH (16),
        .DATA_MOD_WIDTH (4)
    ) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .ser_data_i       (ser_data),
        .ser_data_val_i   (ser_data_val),
        .deser_data_o     (deser_data),
        .deser_data_mod_o (deser_data_mod),
        .deser_data_val_o (deser_data_val),
`ifdef DESERIALIZER_ERR_EN
        .err_o            (err),
`endif
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, return on the next falling edge.
    task automatic tick(input logic v, input logic b);
        ser_data_val = v;
        ser_data     = b;
        @(negedge clk);
        if (deser_data_val === 1'b1) strobes++;
`ifdef DESERIALIZER_ERR_EN
        if (err === 1'b1) err_pulses++;
`endif
    endtask

    task automatic send_bits(input logic [15:0] word, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, word[15-i]);
    endtask

    int base;

    initial begin
        srst = 1'b1;
        ser_data = 1'b0;
        ser_data_val = 1'b0;
        @(negedge clk);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("rst_data", deser_data, 16'h0000);
        check("rst_mod", deser_data_mod, 4'h0);
        check("rst_val", deser_data_val, 1'b0);
        check("rst_busy", busy, 1'b0);
        srst = 1'b0;
        tick(1'b0, 1'b0);
        strobes = 0;

        // Full 16-bit burst 0xA5C3
        tick(1'b1, 1'b1);
        check("full_busy_first", busy, 1'b1);
        send_bits(16'h4B86, 15);
        check("full_val", deser_data_val, 1'b1);
        check("full_data", deser_data, 16'hA5C3);
        check("full_mod", deser_data_mod, 4'h0);
        check("full_busy_end", busy, 1'b0);
        check("full_strobes", strobes, 1);
        tick(1'b0, 1'b0);
        check("full_val_drop", deser_data_val, 1'b0);
        check("full_hold", deser_data, 16'hA5C3);

        // Short 5-bit burst 1,0,1,1,0
        base = strobes;
        send_bits(16'hB000, 5);
        check("short5_no_early", deser_data_val, 1'b0);
        tick(1'b0, 1'b0);
        check("short5_val", deser_data_val, 1'b1);
        check("short5_data", deser_data, 16'hB000);
        check("short5_mod", deser_data_mod, 4'd5);
        tick(1'b0, 1'b0);
        check("short5_strobes", strobes - base, 1);

        // 2-bit burst is dropped
        base = strobes;
        send_bits(16'hC000, 2);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("drop2_strobes", strobes - base, 0);
        check("drop2_data_hold", deser_data, 16'hB000);
        check("drop2_mod_hold", deser_data_mod, 4'd5);
`ifdef DESERIALIZER_ERR_EN
        check("drop2_err_pulses", err_pulses, 1);
`endif

        // 20 bits back-to-back: full word then a 4-bit tail
        base = strobes;
        send_bits(16'hFFFF, 16);
        check("b2b_val1", deser_data_val, 1'b1);
        check("b2b_data1", deser_data, 16'hFFFF);
        check("b2b_mod1", deser_data_mod, 4'h0);
        tick(1'b1, 1'b1);
        check("b2b_no_gap_busy", busy, 1'b1);
        check("b2b_val_gap", deser_data_val, 1'b0);
        send_bits(16'h4000, 3);
        tick(1'b0, 1'b0);
        check("b2b_val2", deser_data_val, 1'b1);
        check("b2b_data2", deser_data, 16'hA000);
        check("b2b_mod2", deser_data_mod, 4'd4);
        tick(1'b0, 1'b0);
        check("b2b_strobes", strobes - base, 2);

        // 15-bit burst: largest short length
        send_bits(16'h1234, 15);
        tick(1'b0, 1'b0);
        check("short15_val", deser_data_val, 1'b1);
        check("short15_data", deser_data, 16'h1234);
        check("short15_mod", deser_data_mod, 4'd15);
        tick(1'b0, 1'b0);

        // Reset after 7 bits of a burst
        base = strobes;
        send_bits(16'hFE00, 7);
        srst = 1'b1;
        tick(1'b1, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_val", deser_data_val, 1'b0);
        check("mrst_data", deser_data, 16'h0000);
        check("mrst_mod", deser_data_mod, 4'h0);
        srst = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("mrst_strobes", strobes - base, 0);
        send_bits(16'hC000, 3);
        tick(1'b0, 1'b0);
        check("post_rst_val", deser_data_val, 1'b1);
        check("post_rst_data", deser_data, 16'hC000);
        check("post_rst_mod", deser_data_mod, 4'd3);
        tick(1'b0, 1'b0);
        check("post_rst_strobes", strobes - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
